piso_serializer: RTL and testbench

//  Parallel-in/serial-out stage that feeds the serial sequence detector.
//  - Accepts WIDTH-bit words over a valid/ready handshake.
//  - Drives them MSB-first, one bit per clock, on dout. dout connects directly to the detector's din.
//  - When no word is in flight, dout holds IDLE_BIT.

---
 rtl/piso_serializer.sv | 100 ++++++++++
 tb/tb_piso_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out stage feeding the sequence detector's din.
// Optional even-parity trailer bit enabled with `define SER_PARITY_EN.
module piso_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [1:0]       state_out
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10,
    BAD    = 2'b11
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             last_bit;
  logic             xfer;

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
  assign xfer     = in_valid && in_ready;

`ifdef SER_PARITY_EN
  logic par_reg;

  // The LSB cycle is followed by the parity cycle, so the next word can only
  // be taken once parity is on the wire.
  assign in_ready = (state == IDLE) || (state == PARITY);
`else
  // Without parity the next word loads on the LSB edge: no gap bit.
  assign in_ready = (state == IDLE) || last_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef SER_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else if (xfer) begin
      state     <= SHIFT;
      bit_cnt   <= '0;
      shift_reg <= in_data;
`ifdef SER_PARITY_EN
      par_reg   <= ^in_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          if (last_bit) begin
`ifdef SER_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // IDLE holds; PARITY lasts one cycle; the unused encoding recovers.
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dout = IDLE_BIT;
    case (state)
      SHIFT:  dout = shift_reg[WIDTH-1];
`ifdef SER_PARITY_EN
      PARITY: dout = par_reg;
`endif
      default: dout = IDLE_BIT;
    endcase
  end

  assign dout_valid  = (state == SHIFT) || (state == PARITY);
  assign frame_start = (state == SHIFT) && (bit_cnt == '0);
  assign busy        = (state != IDLE);
  assign state_out   = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed steps plus random traffic against a
// bit-queue reference model (queue front = bit on the wire after each edge).
module tb_piso_serializer;

  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;
  logic [1:0]       state_out;

  piso_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_start(frame_start),
    .busy       (busy),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic first;
    logic par;
  } ebit_t;

  ebit_t q[$];
  int    tests = 0;
  int    fails = 0;
  bit    last_xfer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the spec's rules, then compare all outputs.
  task automatic tick();
    bit               rdy;
    logic [WIDTH-1:0] w;
    ebit_t            e;
    logic [1:0]       st;
    rdy       = (q.size() <= 1);
    last_xfer = in_valid && rdy && !rst;
    w         = in_data;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (last_xfer) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          e.b = w[i]; e.first = (i == WIDTH - 1); e.par = 1'b0;
          q.push_back(e);
        end
        if (PAR) begin
          e.b = ^w; e.first = 1'b0; e.par = 1'b1;
          q.push_back(e);
        end
      end
    end
    #1;
    st = (q.size() == 0) ? 2'b00 : (q[0].par ? 2'b10 : 2'b01);
    check("in_ready",    32'(in_ready),    32'(q.size() <= 1));
    check("dout",        32'(dout),        32'((q.size() > 0) ? q[0].b : IDLE_BIT));
    check("dout_valid",  32'(dout_valid),  32'(q.size() > 0));
    check("frame_start", 32'(frame_start), 32'((q.size() > 0) && q[0].first));
    check("busy",        32'(busy),        32'(q.size() > 0));
    check("state_out",   32'(state_out),   32'(st));
  endtask

  initial begin
    logic [WIDTH-1:0] got;
    logic [15:0]      cap;
    int               n;
    int               nacc;

    // 1. reset with a word offered: dropped
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    tick(); tick();
    check("rst_state", 32'(state_out), 32'(2'b00));
    check("rst_ready", 32'(in_ready), 32'(1'b1));
    rst = 1'b0; in_valid = 1'b0;
    tick();

    // 2. single word A5
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("t2_frame_start", 32'(frame_start), 32'(1'b1));
    for (int i = 0; i < WIDTH; i++) begin
      got[WIDTH-1-i] = dout;
      tick();
    end
    check("t2_word", 32'(got), 32'(8'hA5));
    check("t2_cycle9_busy", 32'(busy), 32'(PAR));
    repeat (2) tick();

    // 3. back-to-back A5, 3C with in_valid held
    in_valid = 1'b1; in_data = 8'hA5; nacc = 0; n = 0; cap = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (last_xfer) begin
        nacc++;
        in_data = 8'h3C;
        if (nacc == 2) in_valid = 1'b0;
      end
      if (dout_valid && state_out == 2'b01) begin
        cap = {cap[14:0], dout};
        n++;
      end
    end
    check("t3_nbits", 32'(n), 32'd16);
    check("t3_stream", 32'(cap), 32'(16'hA53C));

    // 4. in_data churns with in_valid high mid-word
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    got[WIDTH-1] = dout;
    for (int i = 1; i < WIDTH - 1; i++) begin
      in_data = WIDTH'($urandom);
      tick();
      got[WIDTH-1-i] = dout;
    end
    in_valid = 1'b0;
    tick();
    got[0] = dout;
    check("t4_word", 32'(got), 32'(8'h5A));
    repeat (3) tick();

    // 5. reset at bit 3 of FF, then 81
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'(1'b0));
    check("t5_dout", 32'(dout), 32'(IDLE_BIT));
    tick();
    in_valid = 1'b1; in_data = 8'h81;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      got[WIDTH-1-i] = dout;
      tick();
    end
    check("t5_word", 32'(got), 32'(8'h81));
    repeat (2) tick();

    // 6. parity words 07 then A5 streamed (model covers trailer bit and spacing)
    in_valid = 1'b1; in_data = 8'h07; nacc = 0;
    for (int c = 0; c < 2 * (WIDTH + 2); c++) begin
      tick();
      if (last_xfer) begin
        nacc++;
        in_data = 8'hA5;
        if (nacc == 2) in_valid = 1'b0;
      end
    end
    check("t6_naccepts", 32'(nacc), 32'd2);

    // random traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = WIDTH'($urandom);
      rst      = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (WIDTH + 2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
